spi_memory: RTL and testbench
=============================

# spi_memory

SPI-slave-accessible 128 × 8 memory for board-level bring-up. It samples the raw SPI pins (SCLK, CS, MOSI) in the system clock domain and decodes one command byte (7-bit address plus a R/W flag). It then either stores one data byte or returns one data byte on MISO. A 4-bit LED debug output mirrors the last written data.

## Interface
- ADDR_WIDTH, 7, address bits (memory depth 2^ADDR_WIDTH bytes)
- DATA_WIDTH, 8, data word width
- FILTER_CYCLES, 3, consecutive stable clk samples required before a conditioned input changes

- clk  input  1  system clock; all logic in this domain
- rst_n  input  1  asynchronous, active-low reset
- sclk_pin  input  1  raw SPI clock (mode 0: idle low, sample rising, drive falling)
- cs_pin  input  1  raw chip select, active low
- miso_pin  output  1  serial data out
- mosi_pin  input  1  raw serial data in
- leds  output  4  debug; low nibble of last byte written

## Operation
- Input conditioning, identical per pin (sclk, cs, mosi):
  - 2-flop synchronizer.
  - Glitch filter: the conditioned value updates only after the synchronized value differs from it for FILTER_CYCLES consecutive clk cycles.
  - Rise and fall pulses: one clk wide, asserted in the cycle the conditioned value changes.
- Frame format is MSB first.
  - Byte 0: A[6:0] followed by the R/W bit (1 = read, 0 = write).
  - Byte 1: data. Host drives it for a write; the slave drives it for a read.
- FSM states: IDLE, GET_ADDR, WRITE_GET, WRITE_STORE, READ_LOAD, READ_XMIT, DONE.
- IDLE to GET_ADDR: conditioned CS falls.
- GET_ADDR:
  - On each conditioned SCLK rise, shift conditioned MOSI into an 8-bit input shift register.
  - After the 8th rise, latch address = sr[7:1].
  - If sr[0]=1, go to READ_LOAD; otherwise go to WRITE_GET.
- Write path:
  - WRITE_GET: shift in 8 more bits on SCLK rises.
  - WRITE_STORE: write mem[addr] <= sr in one clk, update leds <= sr[3:0], then go to DONE.
- Read path:
  - READ_LOAD: output shift register <= mem[addr] in one clk, then go to READ_XMIT.
  - READ_XMIT: on each conditioned SCLK fall, miso <= out_sr[7] and out_sr shifts left one bit.
  - After 8 falls, go to DONE.
  - The MISO bit is held until the next fall; the host samples it on the SCLK rise.
- DONE: ignore all SCLK activity until CS rises.
- Conditioned CS rise in any state:
  - Return to IDLE immediately and drive miso 0.
  - Abort any partial frame; an incomplete write never modifies memory.
- miso is 0 in every state except READ_XMIT.
- Memory is not reset; contents are undefined until written.

## Timing
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE.
  - Shift registers, bit counter, miso, leds and conditioned pins are cleared to 0.
  - Conditioned CS resets to 1 (deselected).
- Pin-to-edge-pulse latency: 2 (sync) + FILTER_CYCLES clk cycles. Pulses shorter than FILTER_CYCLES are rejected.
- Host requirement: every SCLK/CS/MOSI phase must be stable for ≥ 2·(2+FILTER_CYCLES) clk cycles.
- MOSI must be stable before the SCLK rise by that same margin.
- Write commit: 1 clk after the 16th conditioned SCLK rise.
- First MISO bit (D7) appears on the first conditioned SCLK fall after the 8th rise. D0 appears on the 8th such fall.
- A CS rise in the same clk as an SCLK edge pulse takes priority: the edge is ignored.

## Test plan
- Reset, then CS high and idle → miso=0, leds=0, FSM IDLE.
- Write: CS low; shift 1111111_0 (addr 0x7F, write), then 0x8D → mem[0x7F]=0x8D, leds=4'hD.
- Read back: CS high then low; shift 0xFF (addr 0x7F, read); issue 8 SCLK falls → MISO sequence 1,0,0,0,1,1,0,1. Two further clocks with CS raised → miso=0.
- Abort: write header to addr 0x05, 4 data bits, then CS high. Reading addr 0x05 returns the prior value and leds are unchanged.
- Glitch: SCLK pulse 2 clk wide during GET_ADDR → no bit shifted; the following clean 8 edges decode correctly.
- Two addresses: write 0x3C to 0x00 and 0xA5 to 0x7E → reads return 0x3C and 0xA5 respectively.

Source files
------------

// File: rtl/spi_memory_if.sv
// -----------------------------------------------------------------------------
// spi_memory_if
//   Bundles the four raw SPI pins seen by the spi_memory slave.
//   Ports (signals):
//     sclk_pin  raw SPI clock, mode 0 (idle low)
//     cs_pin    raw chip select, active low
//     mosi_pin  raw serial data from host
//     miso_pin  serial data to host
//   Modports:
//     master  host side (drives sclk/cs/mosi, reads miso)
//     slave   memory side (reads sclk/cs/mosi, drives miso)
// -----------------------------------------------------------------------------
interface spi_memory_if;
  logic sclk_pin;
  logic cs_pin;
  logic mosi_pin;
  logic miso_pin;

  modport master (
    output sclk_pin,
    output cs_pin,
    output mosi_pin,
    input  miso_pin
  );

  modport slave (
    input  sclk_pin,
    input  cs_pin,
    input  mosi_pin,
    output miso_pin
  );
endinterface

// File: rtl/spi_memory.sv
// -----------------------------------------------------------------------------
// spi_memory
//   SPI-slave-accessible 2^ADDR_WIDTH x DATA_WIDTH memory for bring-up.
//   Raw SPI pins are synchronised and glitch-filtered in the clk domain,
//   then a command byte {addr, rw} selects a one-byte write or read.
//   Ports:
//     clk    system clock; every register lives in this domain
//     rst_n  asynchronous active-low reset
//     spi    spi_memory_if.slave (sclk_pin, cs_pin, mosi_pin in; miso_pin out)
//     leds   low nibble of the last byte written
// -----------------------------------------------------------------------------
module spi_memory #(
  parameter int ADDR_WIDTH    = 7,
  parameter int DATA_WIDTH    = 8,
  parameter int FILTER_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_memory_if.slave      spi,
  output logic [3:0]       leds
);

  localparam int CMD_BITS = ADDR_WIDTH + 1;
  localparam int MAX_BITS = (CMD_BITS > DATA_WIDTH) ? CMD_BITS : DATA_WIDTH;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);
  localparam int FLT_W    = $clog2(FILTER_CYCLES) + 1;
  localparam int DEPTH    = 2 ** ADDR_WIDTH;

  // Pin index 0 = sclk, 1 = cs, 2 = mosi. CS idles high (deselected).
  localparam logic [2:0] PIN_RST = 3'b010;

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, WRITE_GET, WRITE_STORE, READ_LOAD, READ_XMIT, DONE
  } state_e;

  // ---------------------------------------------------------------------------
  // Input conditioning: 2-flop sync, persistence filter, edge pulses
  // ---------------------------------------------------------------------------
  logic [2:0] pin_raw;
  logic [2:0] cond_vec;
  logic [2:0] rise_vec;
  logic [2:0] fall_vec;

  assign pin_raw = {spi.mosi_pin, spi.cs_pin, spi.sclk_pin};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cond
    logic             sync1_q;
    logic             sync2_q;
    logic             cond_q;
    logic             rise_q;
    logic             fall_q;
    logic [FLT_W-1:0] flt_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q   <= PIN_RST[gi];
        sync2_q   <= PIN_RST[gi];
        cond_q    <= PIN_RST[gi];
        rise_q    <= 1'b0;
        fall_q    <= 1'b0;
        flt_cnt_q <= '0;
      end else begin
        sync1_q <= pin_raw[gi];
        sync2_q <= sync1_q;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        if (sync2_q != cond_q) begin
          // The new level must persist for FILTER_CYCLES samples in a row.
          if (flt_cnt_q == FLT_W'(FILTER_CYCLES - 1)) begin
            cond_q    <= sync2_q;
            flt_cnt_q <= '0;
            rise_q    <= sync2_q;
            fall_q    <= ~sync2_q;
          end else begin
            flt_cnt_q <= flt_cnt_q + 1'b1;
          end
        end else begin
          flt_cnt_q <= '0;
        end
      end
    end

    assign cond_vec[gi] = cond_q;
    assign rise_vec[gi] = rise_q;
    assign fall_vec[gi] = fall_q;
  end

  logic sclk_rise;
  logic sclk_fall;
  logic cs_rise;
  logic cs_fall;
  logic mosi_c;

  assign sclk_rise = rise_vec[0];
  assign sclk_fall = fall_vec[0];
  assign cs_rise   = rise_vec[1];
  assign cs_fall   = fall_vec[1];
  assign mosi_c    = cond_vec[2];

  // Levels/edges not needed by the protocol logic.
  logic unused_pins;
  assign unused_pins = ^{cond_vec[1:0], rise_vec[2], fall_vec[2]};

  // ---------------------------------------------------------------------------
  // Datapath registers and memory
  // ---------------------------------------------------------------------------
  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   sr_q;
  logic [DATA_WIDTH-1:0]   out_sr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [CNT_W-1:0]        bit_cnt_q;
  logic                    miso_q;
  logic [3:0]              leds_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic shift_in_en;
  logic last_bit;
  logic store_en;
  logic load_en;
  logic xmit_en;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a conditioned CS rise overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (cs_fall) state_d = GET_ADDR;
      GET_ADDR:    if (sclk_rise && bit_cnt_q == CNT_W'(CMD_BITS - 1))
                     state_d = mosi_c ? READ_LOAD : WRITE_GET;
      WRITE_GET:   if (sclk_rise && bit_cnt_q == CNT_W'(DATA_WIDTH - 1))
                     state_d = WRITE_STORE;
      WRITE_STORE: state_d = DONE;
      READ_LOAD:   state_d = READ_XMIT;
      // After the last fall, D0 stays on miso until the host's sampling
      // rise has been seen; only then is the frame finished.
      READ_XMIT:   if (sclk_rise && bit_cnt_q == CNT_W'(DATA_WIDTH))
                     state_d = DONE;
      DONE:        state_d = DONE;
      default:     state_d = IDLE;
    endcase
    if (cs_rise) state_d = IDLE;
  end

  // Output/enable decode; an edge coinciding with a CS rise is dropped.
  always_comb begin
    shift_in_en = 1'b0;
    last_bit    = 1'b0;
    store_en    = 1'b0;
    load_en     = 1'b0;
    xmit_en     = 1'b0;
    if (!cs_rise) begin
      case (state_q)
        GET_ADDR: begin
          shift_in_en = sclk_rise;
          last_bit    = sclk_rise && (bit_cnt_q == CNT_W'(CMD_BITS - 1));
        end
        WRITE_GET: begin
          shift_in_en = sclk_rise;
          last_bit    = sclk_rise && (bit_cnt_q == CNT_W'(DATA_WIDTH - 1));
        end
        WRITE_STORE: store_en = 1'b1;
        READ_LOAD:   load_en  = 1'b1;
        READ_XMIT:   xmit_en  = sclk_fall && (bit_cnt_q < CNT_W'(DATA_WIDTH));
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q      <= '0;
      out_sr_q  <= '0;
      addr_q    <= '0;
      bit_cnt_q <= '0;
      miso_q    <= 1'b0;
      leds_q    <= '0;
    end else begin
      if (shift_in_en) begin
        sr_q      <= {sr_q[DATA_WIDTH-2:0], mosi_c};
        bit_cnt_q <= last_bit ? '0 : bit_cnt_q + 1'b1;
      end
      // On the last command bit sr_q still holds the address bits; the
      // incoming bit is the R/W flag.
      if (last_bit && state_q == GET_ADDR) begin
        addr_q <= sr_q[ADDR_WIDTH-1:0];
      end
      if (store_en) begin
        leds_q <= sr_q[3:0];
      end
      if (load_en) begin
        out_sr_q  <= mem_q[addr_q];
        bit_cnt_q <= '0;
      end
      if (xmit_en) begin
        miso_q    <= out_sr_q[DATA_WIDTH-1];
        out_sr_q  <= out_sr_q << 1;
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
      if (state_d == IDLE) begin
        bit_cnt_q <= '0;
      end
      if (state_d != READ_XMIT) begin
        miso_q <= 1'b0;
      end
    end
  end

  // Memory contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (store_en) begin
      mem_q[addr_q] <= sr_q;
    end
  end

  assign spi.miso_pin = miso_q;
  assign leds         = leds_q;

endmodule

// File: tb/tb_spi_memory.sv
// -----------------------------------------------------------------------------
// tb_spi_memory
//   Drives SPI frames as a host, keeps an array model of the memory and LEDs,
//   pushes expected results into queues at issue time; an independent pin
//   monitor rebuilds each frame and checks it against the queues.
// -----------------------------------------------------------------------------
module tb_spi_memory;
  localparam int F        = 3;
  localparam int CLK_NS   = 10;
  localparam int MIN_PH   = 2 * (2 + F);
  localparam int PH       = MIN_PH + 2;
  localparam time MIN_HI  = MIN_PH * CLK_NS;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] leds;

  spi_memory_if spi ();

  spi_memory #(
    .ADDR_WIDTH   (7),
    .DATA_WIDTH   (8),
    .FILTER_CYCLES(F)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .spi  (spi),
    .leds (leds)
  );

  always #(CLK_NS / 2) clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model
  logic [7:0] ref_mem [128];
  logic [3:0] ref_leds;
  logic [6:0] written[$];

  // Scoreboard queues
  logic [7:0] exp_rd_q[$];
  logic [3:0] exp_leds_q[$];

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  bit  mon_en = 1'b0;
  bit  mon_mosi[$];
  bit  mon_miso[$];
  bit  pend_mosi, pend_miso;
  time t_rise;

  always @(negedge spi.cs_pin) begin
    mon_mosi.delete();
    mon_miso.delete();
  end

  always @(posedge spi.sclk_pin) begin
    if (spi.cs_pin === 1'b0) begin
      t_rise    = $time;
      pend_mosi = spi.mosi_pin;
      pend_miso = spi.miso_pin;
    end
  end

  // Only a high phase long enough to pass the filter counts as a bit.
  always @(negedge spi.sclk_pin) begin
    if (spi.cs_pin === 1'b0 && ($time - t_rise) >= MIN_HI) begin
      mon_mosi.push_back(pend_mosi);
      mon_miso.push_back(pend_miso);
    end
  end

  always @(posedge spi.cs_pin) begin
    if (mon_en) begin
      logic [7:0] cmd, cmd_miso, rd;
      int nb;
      nb = mon_mosi.size();
      cmd = '0; cmd_miso = '0; rd = '0;
      for (int i = 0; i < 8 && i < nb; i++) begin
        cmd      = {cmd[6:0], mon_mosi[i]};
        cmd_miso = {cmd_miso[6:0], mon_miso[i]};
      end
      $display("frame: bits=%0d cmd=0x%02h leds=0x%0h", nb, cmd, leds);
      if (exp_leds_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL leds_queue: got empty queue, expected an entry");
      end else begin
        check("leds", leds, exp_leds_q.pop_front());
      end
      if (nb >= 8) check("miso_during_cmd", cmd_miso, 8'h00);
      if (nb == 16 && cmd[0] == 1'b1) begin
        for (int i = 8; i < 16; i++) rd = {rd[6:0], mon_miso[i]};
        $display("read: addr=0x%02h data=0x%02h", cmd[7:1], rd);
        if (exp_rd_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL read_queue: got unexpected read 0x%02h, expected none", rd);
        end else begin
          check("read_data", rd, exp_rd_q.pop_front());
        end
      end
      repeat (MIN_PH + 2) @(negedge clk);
      check("miso_after_cs", spi.miso_pin, 1'b0);
    end
  end

  // ---------------------------------------------------------------------------
  // Host driver
  // ---------------------------------------------------------------------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    spi.mosi_pin = b;
    wait_clk(PH);
    spi.sclk_pin = 1'b1;
    wait_clk(PH);
    spi.sclk_pin = 1'b0;
  endtask

  task automatic glitch_pulse();
    wait_clk(PH);
    spi.sclk_pin = 1'b1;
    wait_clk(2);
    spi.sclk_pin = 1'b0;
  endtask

  // ndata < 8 aborts the frame early by raising CS.
  task automatic frame(input logic [6:0] addr, input logic rw, input logic [7:0] data,
                       input int ndata, input bit glitch);
    logic [7:0] cmd;
    cmd = {addr, rw};
    if (ndata == 8) begin
      if (rw) begin
        exp_rd_q.push_back(ref_mem[addr]);
      end else begin
        ref_mem[addr] = data;
        ref_leds      = data[3:0];
        written.push_back(addr);
      end
    end
    exp_leds_q.push_back(ref_leds);

    spi.cs_pin = 1'b0;
    wait_clk(PH);
    for (int i = 7; i >= 0; i--) begin
      send_bit(cmd[i]);
      if (glitch && i == 4) glitch_pulse();
    end
    for (int k = 0; k < ndata; k++) begin
      if (rw) send_bit(1'($urandom_range(0, 1)));
      else    send_bit(data[7-k]);
    end
    wait_clk(PH);
    spi.cs_pin = 1'b1;
    wait_clk(3 * PH);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    ref_leds     = 4'h0;
    spi.cs_pin   = 1'b1;
    spi.sclk_pin = 1'b0;
    spi.mosi_pin = 1'b0;
    rst_n        = 1'b0;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(3 * PH);
    mon_en = 1'b1;

    check("reset_miso", spi.miso_pin, 1'b0);
    check("reset_leds", leds, 4'h0);

    // Write then read back the top address.
    frame(7'h7F, 1'b0, 8'h8D, 8, 1'b0);
    frame(7'h7F, 1'b1, 8'h00, 8, 1'b0);

    // Aborted write must not disturb memory or LEDs.
    frame(7'h05, 1'b0, 8'h62, 8, 1'b0);
    frame(7'h05, 1'b0, 8'hF7, 4, 1'b0);
    frame(7'h05, 1'b1, 8'h00, 8, 1'b0);

    // Short SCLK glitch during the command byte.
    frame(7'h11, 1'b0, 8'h93, 8, 1'b1);
    frame(7'h11, 1'b1, 8'h00, 8, 1'b1);

    // Two distinct addresses.
    frame(7'h00, 1'b0, 8'h3C, 8, 1'b0);
    frame(7'h7E, 1'b0, 8'hA5, 8, 1'b0);
    frame(7'h00, 1'b1, 8'h00, 8, 1'b0);
    frame(7'h7E, 1'b1, 8'h00, 8, 1'b0);

    // Randomised mix of reads, writes, aborts and glitches.
    for (int n = 0; n < 20; n++) begin
      logic [6:0] a;
      logic       rw;
      int         nd;
      bit         g;
      rw = 1'($urandom_range(0, 1));
      if (rw) a = written[$urandom_range(0, written.size() - 1)];
      else    a = 7'($urandom_range(0, 127));
      nd = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : 8;
      g  = ($urandom_range(0, 4) == 0);
      frame(a, rw, 8'($urandom), nd, g);
    end

    wait_clk(PH);
    n_checks++;
    if (exp_rd_q.size() != 0 || exp_leds_q.size() != 0) begin
      n_fail++;
      $display("FAIL queues_drained: got %0d reads and %0d leds left, expected 0 and 0",
               exp_rd_q.size(), exp_leds_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #(200_000 * CLK_NS);
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
